// File: rtl/core_mdu_arbiter_if.sv
// Requester, response and MDU-side signal bundle for core_mdu_arbiter.
// master is the arbiter's view; slave is the surrounding core/MDU.
interface core_mdu_arbiter_if #(
   parameter int XLEN = 64
);
   logic            flush;
   logic            rq0_valid;
   logic            rq0_ready;
   logic [2:0]      rq0_op;
   logic            rq0_word;
   logic [XLEN-1:0] rq0_rs1;
   logic [XLEN-1:0] rq0_rs2;
   logic            rq1_valid;
   logic            rq1_ready;
   logic [2:0]      rq1_op;
   logic            rq1_word;
   logic [XLEN-1:0] rq1_rs1;
   logic [XLEN-1:0] rq1_rs2;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_src;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_err;
   logic            mdu_valid;
   logic            mdu_flush;
   logic            mdu_word;
   logic [7:0]      mdu_op;
   logic [XLEN-1:0] mdu_rs1;
   logic [XLEN-1:0] mdu_rs2;
   logic            mdu_ready;
   logic [XLEN-1:0] mdu_rd;

   modport master (
      input  flush,
      input  rq0_valid, rq0_op, rq0_word, rq0_rs1, rq0_rs2,
      output rq0_ready,
      input  rq1_valid, rq1_op, rq1_word, rq1_rs1, rq1_rs2,
      output rq1_ready,
      output rsp_valid, rsp_src, rsp_data, rsp_err,
      input  rsp_ready,
      output mdu_valid, mdu_flush, mdu_word, mdu_op, mdu_rs1, mdu_rs2,
      input  mdu_ready, mdu_rd
   );

   modport slave (
      output flush,
      output rq0_valid, rq0_op, rq0_word, rq0_rs1, rq0_rs2,
      input  rq0_ready,
      output rq1_valid, rq1_op, rq1_word, rq1_rs1, rq1_rs2,
      input  rq1_ready,
      input  rsp_valid, rsp_src, rsp_data, rsp_err,
      output rsp_ready,
      input  mdu_valid, mdu_flush, mdu_word, mdu_op, mdu_rs1, mdu_rs2,
      output mdu_ready, mdu_rd
   );
endinterface

// File: rtl/core_mdu_arbiter.sv
// Two-requester round-robin front end for a shared multiply/divide unit,
// with a RUN watchdog and a one-cycle MDU flush after every operation.
//
// state | meaning
// IDLE  | waiting for a request; grants one combinationally
// RUN   | operation presented to the MDU, watchdog counting
// RESP  | result (or timeout error) held until rsp_ready
// CLEAR | one cycle of mdu_flush to drop the MDU completion status
module core_mdu_arbiter #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 127
) (
   input logic g_clk,
   input logic g_reset,
   core_mdu_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, RESP, CLEAR} state_t;

   state_t          state_q, state_d;
   logic            prio_q;
   logic [7:0]      wdog_q;
   logic [2:0]      op_q;
   logic            word_q;
   logic            src_q;
   logic [XLEN-1:0] rs1_q, rs2_q, data_q;
   logic            err_q;
   logic            gnt1, take, wdog_tc;

   assign gnt1    = bus.rq1_valid && (!bus.rq0_valid || prio_q);
   assign take    = (state_q == IDLE) && !bus.flush && !g_reset &&
                    (bus.rq0_valid || bus.rq1_valid);
   assign wdog_tc = (wdog_q == 8'(TIMEOUT - 1));

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (take) state_d = RUN;
         RUN: begin
            if (bus.flush)                      state_d = CLEAR;
            else if (bus.mdu_ready || wdog_tc)  state_d = RESP;
         end
         RESP:  if (bus.rsp_ready || bus.flush) state_d = CLEAR;
         CLEAR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         prio_q <= 1'b0;
         wdog_q <= '0;
         op_q   <= '0;
         word_q <= 1'b0;
         src_q  <= 1'b0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (take) begin
         prio_q <= ~gnt1;
         wdog_q <= '0;
         src_q  <= gnt1;
         op_q   <= gnt1 ? bus.rq1_op   : bus.rq0_op;
         word_q <= gnt1 ? bus.rq1_word : bus.rq0_word;
         rs1_q  <= gnt1 ? bus.rq1_rs1  : bus.rq0_rs1;
         rs2_q  <= gnt1 ? bus.rq1_rs2  : bus.rq0_rs2;
      end else if (state_q == RUN && !bus.flush) begin
         // a completion in the terminal watchdog cycle still beats the timeout
         if (bus.mdu_ready) begin
            data_q <= bus.mdu_rd;
            err_q  <= 1'b0;
         end else if (wdog_tc) begin
            data_q <= '0;
            err_q  <= 1'b1;
         end else begin
            wdog_q <= wdog_q + 8'd1;
         end
      end
   end

   assign bus.rq0_ready = take && !gnt1;
   assign bus.rq1_ready = take && gnt1;
   assign bus.mdu_valid = (state_q == RUN);
   assign bus.mdu_op    = (state_q == RUN) ? (8'd1 << op_q) : 8'd0;
   assign bus.mdu_word  = word_q;
   assign bus.mdu_rs1   = rs1_q;
   assign bus.mdu_rs2   = rs2_q;
   assign bus.mdu_flush = !g_reset && ((state_q == CLEAR) || bus.flush);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_src   = src_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_core_mdu_arbiter.sv
// Directed bench for core_mdu_arbiter: vector table of complete transactions
// plus hand sequences for flush and asynchronous reset.
module tb_core_mdu_arbiter;
   localparam int XLEN    = 64;
   localparam int TIMEOUT = 127;
   // requester 1 gets perturbed operands/opcode so a wrong-source latch shows up
   localparam logic [63:0] K1 = 64'h0000_0000_0001_0000;
   localparam logic [63:0] K2 = 64'h0100_0000_0000_0000;

   logic g_clk = 1'b0;
   logic g_reset;
   int   checks = 0;
   int   errors = 0;

   core_mdu_arbiter_if #(.XLEN(XLEN)) bus ();
   core_mdu_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .bus     (bus)
   );

   always #5 g_clk = ~g_clk;

   typedef struct {
      logic [1:0]  vmask;
      logic [2:0]  op;
      logic        word;
      logic [63:0] rs1;
      logic [63:0] rs2;
      int          lat;
      logic [63:0] rd;
      int          hold;
      logic        exp_src;
      logic        exp_err;
      logic [63:0] exp_data;
      int          exp_cycles;
   } vec_t;

   vec_t vec [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts just after a negedge with the DUT in IDLE; ends the same way.
   task automatic run_txn(input vec_t v);
      logic [2:0]  eop;
      logic [63:0] ers1, ers2;
      int          n;
      logic        bad;
      eop  = v.exp_src ? (v.op ^ 3'd1) : v.op;
      ers1 = v.exp_src ? (v.rs1 ^ K1) : v.rs1;
      ers2 = v.exp_src ? (v.rs2 ^ K2) : v.rs2;
      bus.rq0_valid = v.vmask[0];
      bus.rq1_valid = v.vmask[1];
      bus.rq0_op = v.op;         bus.rq1_op = v.op ^ 3'd1;
      bus.rq0_word = v.word;     bus.rq1_word = v.word;
      bus.rq0_rs1 = v.rs1;       bus.rq1_rs1 = v.rs1 ^ K1;
      bus.rq0_rs2 = v.rs2;       bus.rq1_rs2 = v.rs2 ^ K2;
      #1;
      chk("grant_rq0", bus.rq0_ready, !v.exp_src);
      chk("grant_rq1", bus.rq1_ready, v.exp_src);
      @(posedge g_clk);
      #1;
      if (v.vmask != 2'b11) begin
         bus.rq0_valid = 1'b0;
         bus.rq1_valid = 1'b0;
      end
      bus.rq0_rs1 = ~v.rs1; bus.rq1_rs1 = ~v.rs1;
      bus.rq0_rs2 = ~v.rs2; bus.rq1_rs2 = ~v.rs2;
      bus.rq0_op  = ~v.op;  bus.rq1_op  = ~v.op;
      n   = 0;
      bad = 1'b0;
      while (n < 300) begin
         @(negedge g_clk);
         if (bus.rsp_valid) break;
         n++;
         if (bus.mdu_valid !== 1'b1 || bus.mdu_op !== (8'd1 << eop) ||
             bus.mdu_rs1 !== ers1 || bus.mdu_rs2 !== ers2 || bus.mdu_word !== v.word ||
             bus.rq0_ready !== 1'b0 || bus.rq1_ready !== 1'b0 || bus.mdu_flush !== 1'b0)
            bad = 1'b1;
         bus.mdu_ready = (n == v.lat);
         bus.mdu_rd    = (n == v.lat) ? v.rd : 64'hdead_beef_dead_beef;
      end
      bus.mdu_ready = 1'b0;
      chk("run_signals", bad, 1'b0);
      chk("run_cycles", n, v.exp_cycles);
      chk("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_src", bus.rsp_src, v.exp_src);
      chk("rsp_data", bus.rsp_data, v.exp_data);
      chk("rsp_err", bus.rsp_err, v.exp_err);
      bad = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge g_clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== v.exp_data || bus.rsp_src !== v.exp_src ||
             bus.rsp_err !== v.exp_err || bus.rq0_ready !== 1'b0 || bus.rq1_ready !== 1'b0)
            bad = 1'b1;
      end
      if (v.hold > 0) chk("resp_hold", bad, 1'b0);
      bus.rsp_ready = 1'b1;
      @(negedge g_clk);
      bus.rsp_ready = 1'b0;
      chk("clear_flush", bus.mdu_flush, 1'b1);
      chk("clear_quiet", {bus.mdu_valid, bus.rsp_valid, bus.rq0_ready, bus.rq1_ready}, 4'b0);
      @(negedge g_clk);
      chk("idle_flush", bus.mdu_flush, 1'b0);
      chk("idle_op", {bus.mdu_valid, bus.mdu_op}, 9'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {bus.rsp_valid, bus.rsp_src, bus.rsp_err, bus.mdu_valid, bus.mdu_flush,
                 bus.mdu_word, bus.rq0_ready, bus.rq1_ready}, 8'd0);
      chk({name, "_op"},   bus.mdu_op, 8'd0);
      chk({name, "_data"}, bus.rsp_data, 64'd0);
      chk({name, "_rs1"},  bus.mdu_rs1, 64'd0);
      chk({name, "_rs2"},  bus.mdu_rs2, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      //            mask   op    w     rs1      rs2      lat  rd                      hold src  err  data                    cycles
      vec[0]  = '{2'b11, 3'd0, 1'b0, 64'd7,   64'd9,   5,   64'h3f,                 0,   1'b0, 1'b0, 64'h3f,                 5};
      vec[1]  = '{2'b11, 3'd2, 1'b0, 64'ha,   64'hb,   5,   64'h111,                0,   1'b1, 1'b0, 64'h111,                5};
      vec[2]  = '{2'b11, 3'd4, 1'b0, 64'h20,  64'h4,   5,   64'h222,                0,   1'b0, 1'b0, 64'h222,                5};
      vec[3]  = '{2'b11, 3'd6, 1'b0, 64'h21,  64'h5,   5,   64'h333,                20,  1'b1, 1'b0, 64'h333,                5};
      vec[4]  = '{2'b01, 3'd0, 1'b0, 64'd3,   64'd5,   66,  64'd15,                 0,   1'b0, 1'b0, 64'd15,                 66};
      vec[5]  = '{2'b10, 3'd5, 1'b0, 64'd100, 64'd7,   0,   64'd0,                  0,   1'b1, 1'b1, 64'd0,                  127};
      vec[6]  = '{2'b01, 3'd5, 1'b0, 64'd99,  64'd3,   127, 64'h1234,               0,   1'b0, 1'b0, 64'h1234,               127};
      vec[7]  = '{2'b01, 3'd7, 1'b0, 64'd50,  64'd6,   128, 64'hffff,               0,   1'b0, 1'b1, 64'd0,                  127};
      vec[8]  = '{2'b10, 3'd6, 1'b1, 64'd8,   64'd0,   1,   64'hffff_ffff_ffff_ffff, 0,   1'b1, 1'b0, 64'hffff_ffff_ffff_ffff, 1};
      vec[9]  = '{2'b01, 3'd1, 1'b0, 64'h77,  64'h88,  3,   64'h55,                 0,   1'b0, 1'b0, 64'h55,                 3};
      vec[10] = '{2'b11, 3'd3, 1'b1, 64'h5,   64'h6,   2,   64'h66,                 0,   1'b0, 1'b0, 64'h66,                 2};

      g_reset = 1'b1;
      bus.flush = 1'b1;
      bus.rq0_valid = 1'b1; bus.rq1_valid = 1'b1;
      bus.rq0_op = 3'd3; bus.rq1_op = 3'd3;
      bus.rq0_word = 1'b1; bus.rq1_word = 1'b1;
      bus.rq0_rs1 = 64'h1; bus.rq0_rs2 = 64'h2;
      bus.rq1_rs1 = 64'h3; bus.rq1_rs2 = 64'h4;
      bus.rsp_ready = 1'b0;
      bus.mdu_ready = 1'b0;
      bus.mdu_rd = 64'd0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge g_clk);
      g_reset = 1'b0;
      bus.flush = 1'b0;
      bus.rq0_valid = 1'b0; bus.rq1_valid = 1'b0;

      for (int i = 0; i < 9; i++) run_txn(vec[i]);

      // flush in IDLE blocks the grant
      bus.flush = 1'b1;
      bus.rq0_valid = 1'b1;
      #1;
      chk("idle_flush_block", {bus.rq0_ready, bus.rq1_ready}, 2'b00);
      chk("idle_flush_out", bus.mdu_flush, 1'b1);
      @(negedge g_clk);
      chk("idle_flush_stay", bus.mdu_valid, 1'b0);
      bus.flush = 1'b0;
      bus.rq0_valid = 1'b0;

      // flush on RUN cycle 10 aborts requester 1
      bus.rq1_valid = 1'b1;
      @(posedge g_clk);
      #1;
      bus.rq1_valid = 1'b0;
      repeat (10) @(negedge g_clk);
      chk("flush_run_valid", bus.mdu_valid, 1'b1);
      bus.flush = 1'b1;
      #1;
      chk("flush_run_mflush", bus.mdu_flush, 1'b1);
      @(posedge g_clk);
      #1;
      bus.flush = 1'b0;
      @(negedge g_clk);
      chk("flush_clear_mflush", bus.mdu_flush, 1'b1);
      chk("flush_clear_quiet", {bus.rsp_valid, bus.mdu_valid}, 2'b00);
      @(negedge g_clk);
      chk("flush_idle", {bus.rsp_valid, bus.mdu_valid, bus.mdu_flush}, 3'b000);
      run_txn(vec[9]);

      // asynchronous reset in the middle of RUN
      bus.rq0_valid = 1'b1;
      bus.rq0_op = 3'd2; bus.rq0_word = 1'b1;
      bus.rq0_rs1 = 64'habc; bus.rq0_rs2 = 64'hdef;
      @(posedge g_clk);
      #1;
      bus.rq0_valid = 1'b0;
      @(negedge g_clk);
      chk("mid_run_active", bus.mdu_valid, 1'b1);
      #2;
      g_reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      @(negedge g_clk);
      g_reset = 1'b0;
      run_txn(vec[10]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/core_mdu_arbiter.md
CORE_MDU_ARBITER -- requirements
Module: core_mdu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width; XL = XLEN-1.
REQ-002 SHALL have parameter TIMEOUT, default 127, the maximum number of RUN cycles before an error completion (1..255).
REQ-003 SHALL have port g_clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port g_reset  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port flush  in  1  pipeline flush; aborts any in-flight operation.
REQ-006 SHALL have ports rq0_valid/rq1_valid  in  1  request from requester 0/1.
REQ-007 SHALL have ports rq0_ready/rq1_ready  out  1  request accepted this cycle.
REQ-008 SHALL have ports rqN_op  in  3  opcode: 0 mul, 1 mulh, 2 mulhu, 3 mulhsu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-009 SHALL have ports rqN_word  in  1  32-bit word operation.
REQ-010 SHALL have ports rqN_rs1/rqN_rs2  in  XLEN  operands.
REQ-011 SHALL have port rsp_valid  out  1, rsp_ready  in  1, rsp_src  out  1 (granted requester), rsp_data  out  XLEN, rsp_err  out  1 (timeout).
REQ-012 SHALL have MDU-side ports mdu_valid  out  1, mdu_flush  out  1, mdu_word  out  1, mdu_op  out  8 (one-hot; bit k = opcode k), mdu_rs1/mdu_rs2  out  XLEN, mdu_ready  in  1, mdu_rd  in  XLEN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, RESP, CLEAR.
REQ-014 IDLE: when flush=0 and any rqN_valid, SHALL assert exactly one rqN_ready combinationally, latch op/word/rs1/rs2/src, and enter RUN.
REQ-015 Arbitration SHALL be round-robin: priority goes to the requester not granted last; after reset requester 0 has priority.
REQ-016 rqN_ready SHALL be 0 in every state except IDLE.
REQ-017 RUN: mdu_valid=1; mdu_op, mdu_word, mdu_rs1 and mdu_rs2 SHALL be driven from the latch and held stable; the watchdog counter SHALL increment each RUN cycle from 0.
REQ-018 RUN with mdu_ready=1 SHALL capture mdu_rd into rsp_data, set rsp_err=0, and enter RESP.
REQ-019 RUN with the counter at TIMEOUT-1 and mdu_ready=0 SHALL set rsp_data=0 and rsp_err=1, and enter RESP; if mdu_ready=1 in the same cycle, mdu_ready wins.
REQ-020 RESP: rsp_valid=1; rsp_src, rsp_data and rsp_err SHALL stay stable until rsp_ready=1, then the FSM enters CLEAR.
REQ-021 CLEAR SHALL last exactly 1 cycle with mdu_flush=1 and mdu_valid=0, then return to IDLE; this is needed because MDU completion status stays asserted until flushed.
REQ-022 mdu_flush SHALL equal (state==CLEAR) OR flush.
REQ-023 flush=1 in RUN or RESP SHALL enter CLEAR next cycle, with no response delivered; rsp_valid=0 from the next cycle.
REQ-024 flush=1 in IDLE SHALL block the grant that cycle.
REQ-025 flush=1 and rsp_ready=1 in the same RESP cycle SHALL be treated as a completed handshake; the next state is CLEAR.
REQ-026 Outside RUN, mdu_valid SHALL be 0 and mdu_op SHALL be 0.
REQ-027 Latency: rsp_valid SHALL rise the cycle after mdu_ready is sampled high in RUN.
REQ-028 Minimum grant-to-grant interval SHALL be RUN cycles + 3 (IDLE, RESP, CLEAR); one request SHALL be in flight at most.
REQ-029 Operand width SHALL be passed through unmodified; word handling is the MDU's job.

Reset
REQ-030 g_reset=1 SHALL immediately, independent of g_clk, force state IDLE, round-robin priority to requester 0, watchdog 0, and the latch to 0.
REQ-031 During reset, rsp_valid, rsp_src, rsp_data, rsp_err, mdu_valid, mdu_flush, mdu_op, mdu_word, mdu_rs1, mdu_rs2, rq0_ready and rq1_ready SHALL all be 0.
REQ-032 The first grant after reset deassertion SHALL occur no earlier than the first rising edge with g_reset=0.

Verification
REQ-033 rq0 mul, rs1=3, rs2=5, word=0; MDU model asserts mdu_ready with rd=15 after 66 RUN cycles -> mdu_op=8'h01 during RUN; rsp_valid with rsp_data=15, rsp_src=0, rsp_err=0; mdu_flush pulses 1 cycle after the rsp handshake.
REQ-034 rq0 and rq1 held valid continuously from reset, each completing in 5 cycles -> grants in the order 0,1,0,1 and rsp_src sequence 0,1,0,1.
REQ-035 rq1 div (op=4), TIMEOUT=127, mdu_ready never asserted -> rsp_valid after exactly 127 RUN cycles with rsp_err=1, rsp_data=0, rsp_src=1.
REQ-036 flush pulsed on RUN cycle 10 -> mdu_flush=1 that cycle and the next; no rsp_valid; FSM back in IDLE; the next rq0 request is granted.
REQ-037 rsp_ready held 0 for 20 cycles in RESP while both requesters are valid -> rsp_data and rsp_src stable; rq0_ready=rq1_ready=0 throughout.
REQ-038 g_reset asserted mid-RUN between clock edges -> all outputs 0 before the next edge; the next request is granted to requester 0.
